// File: rtl/stream_upsizer_pkg.sv
// Shared widths, fill-state encoding and helpers for the 32-to-256 stream upsizer.
// The STREAM_UPSIZER_PERF_CNT_EN build option uses CNT_W for its counter width.
package stream_upsizer_pkg;

    localparam int DIN_W  = 32;
    localparam int DOUT_W = 256;
    localparam int RATIO  = DOUT_W / DIN_W;
    localparam int CNT_W  = 32;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

    localparam int FILL_W = clog2(RATIO);

    typedef enum logic {
        FILL,
        LAST_SLOT
    } fillState_e;

    // Bit i set for every word slot at or below the closing word's position.
    function automatic logic [RATIO-1:0] keep_mask(input logic [FILL_W-1:0] count);
        logic [RATIO-1:0] mask;
        mask = '0;
        for (int i = 0; i < RATIO; i++) begin
            mask[i] = (i <= int'(count));
        end
        return mask;
    endfunction

endpackage

// File: rtl/stream_perf_cnt.sv
// Saturating event counter used for the optional upsizer performance statistics
// (enabled by STREAM_UPSIZER_PERF_CNT_EN in the top level).
module stream_perf_cnt
    import stream_upsizer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/stream_upsizer_32to256.sv
// Packs 32-bit valid/ready words little-endian into 256-bit beats; din_last flushes a
// partial, zero-padded group. Define STREAM_UPSIZER_PERF_CNT_EN for traffic counters.
module stream_upsizer_32to256
    import stream_upsizer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DIN_W-1:0]  din_data,
    input  logic              din_valid,
    input  logic              din_last,
    output logic              din_ready,
    output logic [DOUT_W-1:0] dout_data,
    output logic [RATIO-1:0]  dout_keep,
    output logic              dout_last,
    output logic              dout_valid,
`ifdef STREAM_UPSIZER_PERF_CNT_EN
    output logic [CNT_W-1:0]  in_word_cnt,
    output logic [CNT_W-1:0]  in_stall_cnt,
    output logic [CNT_W-1:0]  out_stall_cnt,
`endif
    input  logic              dout_ready
);

    fillState_e        state_q;
    logic [FILL_W-1:0] count_q;
    logic [DIN_W-1:0]  slot_q [RATIO-1];
    logic              readyEn_q;
    logic [DOUT_W-1:0] data_q;
    logic [RATIO-1:0]  keep_q;
    logic              last_q;
    logic              valid_q;
    logic [DOUT_W-1:0] beat_d;

    logic closingWord;
    logic outFree;
    logic inFire;
    logic outFire;

    // A closing word needs the output register to be free this cycle or emptying now.
    assign closingWord = (state_q == LAST_SLOT) || din_last;
    assign outFree     = !valid_q || dout_ready;
    assign din_ready   = readyEn_q && (!closingWord || outFree);
    assign inFire      = din_valid && din_ready;
    assign outFire     = valid_q && dout_ready;

    always_comb begin
        beat_d = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            if (FILL_W'(i) < count_q) begin
                beat_d[i*DIN_W +: DIN_W] = slot_q[i];
            end
        end
        for (int i = 0; i < RATIO; i++) begin
            if (FILL_W'(i) == count_q) begin
                beat_d[i*DIN_W +: DIN_W] = din_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FILL;
            count_q   <= '0;
            readyEn_q <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
            for (int i = 0; i < RATIO - 1; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            readyEn_q <= 1'b1;
            if (outFire) begin
                valid_q <= 1'b0;
            end
            if (inFire) begin
                if (closingWord) begin
                    data_q  <= beat_d;
                    keep_q  <= keep_mask(count_q);
                    last_q  <= din_last;
                    valid_q <= 1'b1;
                    count_q <= '0;
                    state_q <= FILL;
                end else begin
                    for (int i = 0; i < RATIO - 1; i++) begin
                        if (FILL_W'(i) == count_q) begin
                            slot_q[i] <= din_data;
                        end
                    end
                    count_q <= count_q + FILL_W'(1);
                    state_q <= (count_q == FILL_W'(RATIO - 2)) ? LAST_SLOT : FILL;
                end
            end
        end
    end

    assign dout_data  = data_q;
    assign dout_keep  = keep_q;
    assign dout_last  = last_q;
    assign dout_valid = valid_q;

`ifdef STREAM_UPSIZER_PERF_CNT_EN
    stream_perf_cnt uInWordCnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (inFire),
        .cnt_o (in_word_cnt)
    );

    stream_perf_cnt uInStallCnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (din_valid && !din_ready),
        .cnt_o (in_stall_cnt)
    );

    stream_perf_cnt uOutStallCnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (valid_q && !dout_ready),
        .cnt_o (out_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_stream_upsizer_32to256.sv
// Scoreboard bench for stream_upsizer_32to256: stimulus pushes expected beats, a monitor
// pops and compares them; perf counter checks build only with STREAM_UPSIZER_PERF_CNT_EN.
module tb_stream_upsizer_32to256;
    import stream_upsizer_pkg::*;

    typedef struct packed {
        logic [255:0] data;
        logic [7:0]   keep;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  din_data;
    logic         din_valid;
    logic         din_last;
    logic         din_ready;
    logic [255:0] dout_data;
    logic [7:0]   dout_keep;
    logic         dout_last;
    logic         dout_valid;
    logic         dout_ready;
`ifdef STREAM_UPSIZER_PERF_CNT_EN
    logic [31:0]  in_word_cnt;
    logic [31:0]  in_stall_cnt;
    logic [31:0]  out_stall_cnt;
`endif

    beat_t expQ[$];
    int    checks      = 0;
    int    errors      = 0;
    int    stallCycles = 0;

    stream_upsizer_32to256 dut (
        .clk           (clk),
        .reset         (reset),
        .din_data      (din_data),
        .din_valid     (din_valid),
        .din_last      (din_last),
        .din_ready     (din_ready),
        .dout_data     (dout_data),
        .dout_keep     (dout_keep),
        .dout_last     (dout_last),
        .dout_valid    (dout_valid),
`ifdef STREAM_UPSIZER_PERF_CNT_EN
        .in_word_cnt   (in_word_cnt),
        .in_stall_cnt  (in_stall_cnt),
        .out_stall_cnt (out_stall_cnt),
`endif
        .dout_ready    (dout_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Offers one word and waits (bounded) until it is accepted.
    task automatic applyStimulus(input logic [31:0] data, input logic last);
        bit fired;
        fired     = 1'b0;
        din_data  = data;
        din_valid = 1'b1;
        din_last  = last;
        for (int t = 0; t < 50 && !fired; t++) begin
            @(negedge clk);
            fired = din_ready;
            if (!fired) stallCycles++;
            @(posedge clk);
            #1;
        end
        if (!fired) begin
            checks++;
            errors++;
            $display("[TB] FAIL input_timeout word=%h actual=not_accepted expected=accepted", data);
        end
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic pushBeat(input logic [255:0] data, input logic [7:0] keep, input logic last);
        beat_t b;
        b.data = data;
        b.keep = keep;
        b.last = last;
        expQ.push_back(b);
    endtask

    task automatic doReset();
        reset     = 1'b1;
        din_valid = 1'b0;
        din_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drainQueue(input string name);
        for (int t = 0; t < 40 && expQ.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        checkOutput(name, 256'(expQ.size()), 256'd0);
    endtask

    // Monitor: every presented beat must match the scoreboard head, held or fired.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && dout_valid) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL beat_unexpected actual=%h/%h/%b expected=none",
                             dout_data, dout_keep, dout_last);
                end else if (dout_data !== expQ[0].data || dout_keep !== expQ[0].keep ||
                             dout_last !== expQ[0].last) begin
                    errors++;
                    $display("[TB] FAIL beat_content actual=%h/%h/%b expected=%h/%h/%b",
                             dout_data, dout_keep, dout_last,
                             expQ[0].data, expQ[0].keep, expQ[0].last);
                end
                if (dout_ready && expQ.size() != 0) void'(expQ.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        din_data   = '0;
        din_valid  = 1'b0;
        din_last   = 1'b0;
        dout_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_valid", 256'(dout_valid), 256'd0);
        checkOutput("reset_data", dout_data, 256'd0);
        checkOutput("reset_keep", 256'(dout_keep), 256'd0);
        checkOutput("reset_last", 256'(dout_last), 256'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_after_reset", 256'(din_ready), 256'd1);

        // Full group, back-to-back
        $display("[TB] full group");
        stallCycles = 0;
        pushBeat({32'h18, 32'h17, 32'h16, 32'h15, 32'h14, 32'h13, 32'h12, 32'h11}, 8'hFF, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(32'h11 + 32'(i), 1'b0);
        checkOutput("full_group_latency", 256'(dout_valid), 256'd1);
        checkOutput("full_group_stalls", 256'(stallCycles), 256'd0);

        // Flush of a three-word group, no bubble after the previous group
        $display("[TB] flush");
        pushBeat({160'h0, 32'h0000000C, 32'h0000000B, 32'h0000000A}, 8'h07, 1'b1);
        applyStimulus(32'h0000000A, 1'b0);
        applyStimulus(32'h0000000B, 1'b0);
        applyStimulus(32'h0000000C, 1'b1);
        checkOutput("flush_stalls", 256'(stallCycles), 256'd0);

        // Single-word flush
        pushBeat({224'h0, 32'h00000055}, 8'h01, 1'b1);
        applyStimulus(32'h00000055, 1'b1);
        drainQueue("drain_after_flush");

        // Back-pressure: 16 words offered with dout_ready low
        $display("[TB] back-pressure");
        dout_ready = 1'b0;
        pushBeat({32'h28, 32'h27, 32'h26, 32'h25, 32'h24, 32'h23, 32'h22, 32'h21}, 8'hFF, 1'b0);
        pushBeat({32'h30, 32'h2F, 32'h2E, 32'h2D, 32'h2C, 32'h2B, 32'h2A, 32'h29}, 8'hFF, 1'b0);
        for (int i = 0; i < 15; i++) applyStimulus(32'h21 + 32'(i), 1'b0);
        din_data  = 32'h30;
        din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_ready_low", 256'(din_ready), 256'd0);
            @(posedge clk);
            #1;
        end
        dout_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_ready_release", 256'(din_ready), 256'd1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        drainQueue("drain_after_bp");

        // Reset in the middle of a group drops the partial words
        $display("[TB] reset mid-group");
        for (int i = 0; i < 5; i++) applyStimulus(32'h91 + 32'(i), 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_valid", 256'(dout_valid), 256'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        pushBeat({32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1}, 8'hFF, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(32'h1 + 32'(i), 1'b0);
        drainQueue("drain_after_midreset");

`ifdef STREAM_UPSIZER_PERF_CNT_EN
        $display("[TB] perf counters");
        doReset();
        checkOutput("perf_reset_in_word", 256'(in_word_cnt), 256'd0);
        checkOutput("perf_reset_in_stall", 256'(in_stall_cnt), 256'd0);
        checkOutput("perf_reset_out_stall", 256'(out_stall_cnt), 256'd0);
        stallCycles = 0;
        pushBeat({32'h48, 32'h47, 32'h46, 32'h45, 32'h44, 32'h43, 32'h42, 32'h41}, 8'hFF, 1'b0);
        pushBeat({192'h0, 32'h4A, 32'h49}, 8'h03, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(32'h41 + 32'(i), 1'b0);
        dout_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        dout_ready = 1'b1;
        applyStimulus(32'h49, 1'b0);
        applyStimulus(32'h4A, 1'b1);
        drainQueue("drain_perf");
        checkOutput("perf_in_word", 256'(in_word_cnt), 256'd10);
        checkOutput("perf_out_stall", 256'(out_stall_cnt), 256'd4);
        checkOutput("perf_in_stall", 256'(in_stall_cnt), 256'(stallCycles));
        force dut.uInWordCnt.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.uInWordCnt.cnt_q;
        pushBeat({192'h0, 32'h62, 32'h61}, 8'h03, 1'b1);
        applyStimulus(32'h61, 1'b0);
        applyStimulus(32'h62, 1'b1);
        checkOutput("perf_saturate", 256'(in_word_cnt), 256'hFFFF_FFFF);
        drainQueue("drain_saturate");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
